// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the SM83 register file and its neighbours.
//   - byte register index, register pair, IDU op and IME op encodings
//   - flag bit positions within the CHNZ flag vector (also used by the ALU)
//   - DMG post-boot register values and the reset-value helper
// Optional build macro: REGFILE_SKIP_BOOT_EN selects post-boot reset values.
package cpu_pkg;

    typedef enum logic [3:0] {
        RegB   = 4'd0,
        RegC   = 4'd1,
        RegD   = 4'd2,
        RegE   = 4'd3,
        RegH   = 4'd4,
        RegL   = 4'd5,
        RegF   = 4'd6,
        RegA   = 4'd7,
        RegW   = 4'd8,
        RegZ   = 4'd9,
        RegSph = 4'd10,
        RegSpl = 4'd11,
        RegPch = 4'd12,
        RegPcl = 4'd13,
        RegNo0 = 4'd14,
        RegNo1 = 4'd15
    } reg_idx_e;

    typedef enum logic [2:0] {
        PairBc   = 3'd0,
        PairDe   = 3'd1,
        PairHl   = 3'd2,
        PairSp   = 3'd3,
        PairAf   = 3'd4,
        PairPc   = 3'd5,
        PairWz   = 3'd6,
        PairNone = 3'd7
    } pair_idx_e;

    typedef enum logic [1:0] {IduNone, IduInc, IduDec, IduLoad} idu_op_e;
    typedef enum logic [1:0] {ImeNone, ImeEi, ImeDi, ImeReti} ime_op_e;
    typedef enum logic [1:0] {StImeOff, StImePending, StImeOn} ime_state_e;

    localparam int unsigned NUM_BYTES = 14;
    // Byte indices at or above this value are unbacked.
    localparam logic [3:0] BYTE_IDX_LIMIT = 4'd14;

    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_H = 1;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_Z = 3;

    localparam logic [7:0] BOOT_A   = 8'h01;
    localparam logic [7:0] BOOT_F   = 8'hB0;
    localparam logic [7:0] BOOT_B   = 8'h00;
    localparam logic [7:0] BOOT_C   = 8'h13;
    localparam logic [7:0] BOOT_D   = 8'h00;
    localparam logic [7:0] BOOT_E   = 8'hD8;
    localparam logic [7:0] BOOT_H   = 8'h01;
    localparam logic [7:0] BOOT_L   = 8'h4D;
    localparam logic [15:0] BOOT_SP = 16'hFFFE;
    localparam logic [15:0] BOOT_PC = 16'h0100;

    // High byte index of a pair; PairNone maps to 0 and must be masked by the caller.
    function automatic logic [3:0] pair_hi(input logic [2:0] pair);
        case (pair)
            PairBc:  return RegB;
            PairDe:  return RegD;
            PairHl:  return RegH;
            PairSp:  return RegSph;
            PairAf:  return RegA;
            PairPc:  return RegPch;
            PairWz:  return RegW;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [3:0] pair_lo(input logic [2:0] pair);
        case (pair)
            PairBc:  return RegC;
            PairDe:  return RegE;
            PairHl:  return RegL;
            PairSp:  return RegSpl;
            PairAf:  return RegF;
            PairPc:  return RegPcl;
            PairWz:  return RegZ;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [7:0] reset_value(input logic [3:0] idx);
`ifdef REGFILE_SKIP_BOOT_EN
        case (idx)
            RegA:    return BOOT_A;
            RegF:    return BOOT_F;
            RegB:    return BOOT_B;
            RegC:    return BOOT_C;
            RegD:    return BOOT_D;
            RegE:    return BOOT_E;
            RegH:    return BOOT_H;
            RegL:    return BOOT_L;
            RegSph:  return BOOT_SP[15:8];
            RegSpl:  return BOOT_SP[7:0];
            RegPch:  return BOOT_PC[15:8];
            RegPcl:  return BOOT_PC[7:0];
            default: return 8'h00;
        endcase
`else
        return (idx == 4'd15) ? 8'h00 : 8'h00;
`endif
    endfunction

endpackage

// File: rtl/cpu_register_file_if.sv
// cpu_register_file_if: bus between the CPU control/ALU side (master) and the
// register file (slave).
//   byte read ports A/B, byte write port, flag write/read, pair read + IDU op,
//   PC/SP taps, IME op / instr_done / ime_out.
interface cpu_register_file_if;
    logic [3:0]  rd_a_sel;
    logic [7:0]  rd_a_data;
    logic [3:0]  rd_b_sel;
    logic [7:0]  rd_b_data;
    logic        wr_en;
    logic [3:0]  wr_sel;
    logic [7:0]  wr_data;
    logic [3:0]  flag_wr_mask;
    logic [3:0]  flag_wr_data;
    logic [3:0]  flags_out;
    logic [2:0]  pair_sel;
    logic [15:0] pair_rd_data;
    logic [1:0]  idu_op;
    logic [15:0] pair_wr_data;
    logic [15:0] pc_out;
    logic [15:0] sp_out;
    logic [1:0]  ime_op;
    logic        instr_done;
    logic        ime_out;

    modport master (
        output rd_a_sel, rd_b_sel, wr_en, wr_sel, wr_data, flag_wr_mask, flag_wr_data,
               pair_sel, idu_op, pair_wr_data, ime_op, instr_done,
        input  rd_a_data, rd_b_data, flags_out, pair_rd_data, pc_out, sp_out, ime_out
    );

    modport slave (
        input  rd_a_sel, rd_b_sel, wr_en, wr_sel, wr_data, flag_wr_mask, flag_wr_data,
               pair_sel, idu_op, pair_wr_data, ime_op, instr_done,
        output rd_a_data, rd_b_data, flags_out, pair_rd_data, pc_out, sp_out, ime_out
    );
endinterface

// File: rtl/cpu_idu.sv
// cpu_idu: combinational 16-bit increment/decrement/load unit.
//   i_operand  current pair value
//   i_op       IduNone / IduInc / IduDec / IduLoad
//   i_load     value used for IduLoad
//   o_result   next pair value (wraps modulo 2^16)
module cpu_idu
    import cpu_pkg::*;
(
    input  logic [15:0] i_operand,
    input  idu_op_e     i_op,
    input  logic [15:0] i_load,
    output logic [15:0] o_result
);
    always_comb begin
        o_result = i_operand;
        case (i_op)
            IduInc:  o_result = i_operand + 16'd1;
            IduDec:  o_result = i_operand - 16'd1;
            IduLoad: o_result = i_load;
            default: o_result = i_operand;
        endcase
    end
endmodule

// File: rtl/cpu_register_file.sv
// cpu_register_file: SM83 architectural registers B..A, F, W/Z, SP, PC and IME.
//   clk, reset_n  clock, asynchronous active-low reset
//   regs_if       slave side of cpu_register_file_if (byte/flag/pair/IME ports)
// Optional build macro: REGFILE_SKIP_BOOT_EN (reset to DMG post-boot values).
module cpu_register_file
    import cpu_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    cpu_register_file_if.slave    regs_if
);
    logic [7:0]  r_bytes      [NUM_BYTES];
    logic [7:0]  w_bytes_next [NUM_BYTES];
    ime_state_e  r_ime_state;
    ime_state_e  w_ime_state_next;
    logic [3:0]  w_pair_hi;
    logic [3:0]  w_pair_lo;
    logic [15:0] w_pair_cur;
    logic [15:0] w_idu_result;
    logic        w_pair_valid;

    assign w_pair_hi    = pair_hi(regs_if.pair_sel);
    assign w_pair_lo    = pair_lo(regs_if.pair_sel);
    assign w_pair_valid = (regs_if.pair_sel != PairNone);
    assign w_pair_cur   = w_pair_valid ? {r_bytes[w_pair_hi], r_bytes[w_pair_lo]} : 16'h0000;

    cpu_idu u_idu (
        .i_operand (w_pair_cur),
        .i_op      (idu_op_e'(regs_if.idu_op)),
        .i_load    (regs_if.pair_wr_data),
        .o_result  (w_idu_result)
    );

    // Pair update first, then the byte write overrides its own byte only,
    // then masked flag bits override whatever F would otherwise become.
    always_comb begin
        for (int i = 0; i < NUM_BYTES; i++) begin
            w_bytes_next[i] = r_bytes[i];
        end
        if (w_pair_valid && (regs_if.idu_op != IduNone)) begin
            w_bytes_next[w_pair_hi] = w_idu_result[15:8];
            w_bytes_next[w_pair_lo] = w_idu_result[7:0];
        end
        if (regs_if.wr_en && (regs_if.wr_sel < BYTE_IDX_LIMIT)) begin
            w_bytes_next[regs_if.wr_sel] = regs_if.wr_data;
        end
        w_bytes_next[RegF] = {(w_bytes_next[RegF][7:4] & ~regs_if.flag_wr_mask) |
                              (regs_if.flag_wr_data & regs_if.flag_wr_mask), 4'h0};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                r_bytes[i] <= reset_value(4'(i));
            end
        end else begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                r_bytes[i] <= w_bytes_next[i];
            end
        end
    end

    // IME state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ime_state <= StImeOff;
        end else begin
            r_ime_state <= w_ime_state_next;
        end
    end

    // IME next state; EI only arms PENDING, the following instr_done enables.
    always_comb begin
        w_ime_state_next = r_ime_state;
        case (ime_op_e'(regs_if.ime_op))
            ImeDi:   w_ime_state_next = StImeOff;
            ImeReti: w_ime_state_next = StImeOn;
            ImeEi: begin
                if (r_ime_state == StImeOff) begin
                    w_ime_state_next = StImePending;
                end
            end
            default: begin
                if ((r_ime_state == StImePending) && regs_if.instr_done) begin
                    w_ime_state_next = StImeOn;
                end
            end
        endcase
    end

    // Outputs
    always_comb begin
        regs_if.ime_out   = (r_ime_state == StImeOn);
        regs_if.rd_a_data = (regs_if.rd_a_sel < BYTE_IDX_LIMIT) ? r_bytes[regs_if.rd_a_sel] : 8'h00;
        regs_if.rd_b_data = (regs_if.rd_b_sel < BYTE_IDX_LIMIT) ? r_bytes[regs_if.rd_b_sel] : 8'h00;
        regs_if.flags_out = r_bytes[RegF][7:4];
        regs_if.pair_rd_data = w_pair_cur;
        regs_if.pc_out    = {r_bytes[RegPch], r_bytes[RegPcl]};
        regs_if.sp_out    = {r_bytes[RegSph], r_bytes[RegSpl]};
    end
endmodule

// File: tb/tb_cpu_register_file.sv
// tb_cpu_register_file: directed self-checking bench with an expected-value scoreboard.
module tb_cpu_register_file;
    import cpu_pkg::*;

`ifdef REGFILE_SKIP_BOOT_EN
    localparam logic [7:0]  INIT_A  = 8'h01;
    localparam logic [7:0]  INIT_F  = 8'hB0;
    localparam logic [7:0]  INIT_C  = 8'h13;
    localparam logic [15:0] INIT_PC = 16'h0100;
    localparam logic [15:0] INIT_SP = 16'hFFFE;
`else
    localparam logic [7:0]  INIT_A  = 8'h00;
    localparam logic [7:0]  INIT_F  = 8'h00;
    localparam logic [7:0]  INIT_C  = 8'h00;
    localparam logic [15:0] INIT_PC = 16'h0000;
    localparam logic [15:0] INIT_SP = 16'h0000;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    cpu_register_file_if rf_if ();

    cpu_register_file u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .regs_if (rf_if.slave)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_q [$];
    string       tag_q [$];
    logic [3:0]  m_flags;

    task automatic expect_val(input string tag, input logic [15:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check_obs(input logic [15:0] obs);
        logic [15:0] exp_v;
        string tag;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            exp_v = exp_q.pop_front();
            tag   = tag_q.pop_front();
            assert (obs === exp_v) else begin
                n_err++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
            end
        end
    endtask

    task automatic idle;
        rf_if.rd_a_sel     = 4'd0;
        rf_if.rd_b_sel     = 4'd0;
        rf_if.wr_en        = 1'b0;
        rf_if.wr_sel       = 4'd0;
        rf_if.wr_data      = 8'h00;
        rf_if.flag_wr_mask = 4'h0;
        rf_if.flag_wr_data = 4'h0;
        rf_if.pair_sel     = PairNone;
        rf_if.idu_op       = IduNone;
        rf_if.pair_wr_data = 16'h0000;
        rf_if.ime_op       = ImeNone;
        rf_if.instr_done   = 1'b0;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pair_load(input logic [2:0] p, input logic [15:0] v);
        idle;
        rf_if.pair_sel     = p;
        rf_if.idu_op       = IduLoad;
        rf_if.pair_wr_data = v;
        tick;
        idle;
    endtask

    initial begin
        idle;
        m_flags = INIT_F[7:4];
        #12;
        // Reset values, sampled mid-cycle with reset held
        rf_if.rd_a_sel = RegA;
        rf_if.rd_b_sel = RegC;
        rf_if.pair_sel = PairAf;
        #1;
        expect_val("rst_a", {8'h00, INIT_A});
        expect_val("rst_c", {8'h00, INIT_C});
        expect_val("rst_pc", INIT_PC);
        expect_val("rst_sp", INIT_SP);
        expect_val("rst_ime", 16'd0);
        expect_val("rst_af", {INIT_A, INIT_F});
        check_obs({8'h00, rf_if.rd_a_data});
        check_obs({8'h00, rf_if.rd_b_data});
        check_obs(rf_if.pc_out);
        check_obs(rf_if.sp_out);
        check_obs({15'd0, rf_if.ime_out});
        check_obs(rf_if.pair_rd_data);
        @(negedge clk);
        reset_n = 1'b1;
        tick;

        // Byte write of A with masked flag update; no write-through before the edge
        idle;
        rf_if.wr_en = 1'b1;
        rf_if.wr_sel = RegA;
        rf_if.wr_data = 8'h3C;
        rf_if.flag_wr_mask = 4'b1010;
        rf_if.flag_wr_data = 4'b1111;
        rf_if.rd_a_sel = RegA;
        #1;
        expect_val("no_write_through", {8'h00, INIT_A});
        check_obs({8'h00, rf_if.rd_a_data});
        m_flags = (m_flags & ~4'b1010) | 4'b1010;
        expect_val("wr_a", 16'h003C);
        expect_val("flags_masked", {12'h000, m_flags});
        expect_val("f_byte", {8'h00, m_flags, 4'h0});
        tick;
        idle;
        rf_if.rd_a_sel = RegA;
        rf_if.rd_b_sel = RegF;
        #1;
        check_obs({8'h00, rf_if.rd_a_data});
        check_obs({12'h000, rf_if.flags_out});
        check_obs({8'h00, rf_if.rd_b_data});

        // AF pair load forces F low nibble to zero
        expect_val("af_load", 16'h12F0);
        expect_val("af_flags", 16'h000F);
        pair_load(PairAf, 16'h12FF);
        rf_if.pair_sel = PairAf;
        #1;
        check_obs(rf_if.pair_rd_data);
        check_obs({12'h000, rf_if.flags_out});

        // HL wrap on INC
        pair_load(PairHl, 16'hFFFF);
        rf_if.pair_sel = PairHl;
        rf_if.idu_op = IduInc;
        expect_val("hl_inc_wrap", 16'h0000);
        tick;
        idle;
        rf_if.pair_sel = PairHl;
        #1;
        check_obs(rf_if.pair_rd_data);

        // SP wrap on DEC
        pair_load(PairSp, 16'h0000);
        rf_if.pair_sel = PairSp;
        rf_if.idu_op = IduDec;
        expect_val("sp_dec_wrap", 16'hFFFF);
        tick;
        idle;
        check_obs(rf_if.sp_out);

        // Byte write overrides only its own half of the IDU result
        pair_load(PairBc, 16'h10FF);
        rf_if.pair_sel = PairBc;
        rf_if.idu_op = IduInc;
        rf_if.wr_en = 1'b1;
        rf_if.wr_sel = RegB;
        rf_if.wr_data = 8'hAA;
        expect_val("bc_inc_byte_prio", 16'hAA00);
        tick;
        idle;
        rf_if.pair_sel = PairBc;
        #1;
        check_obs(rf_if.pair_rd_data);

        // Unbacked byte index and pair 7
        rf_if.wr_en = 1'b1;
        rf_if.wr_sel = 4'd14;
        rf_if.wr_data = 8'h55;
        rf_if.pair_sel = PairNone;
        rf_if.idu_op = IduLoad;
        rf_if.pair_wr_data = 16'h1234;
        expect_val("idx14_read", 16'h0000);
        expect_val("pair7_read", 16'h0000);
        tick;
        idle;
        rf_if.rd_a_sel = 4'd14;
        rf_if.pair_sel = PairNone;
        #1;
        check_obs({8'h00, rf_if.rd_a_data});
        check_obs(rf_if.pair_rd_data);

        // PC increment from its reset value
        rf_if.pair_sel = PairPc;
        rf_if.idu_op = IduInc;
        expect_val("pc_inc", INIT_PC + 16'd1);
        tick;
        idle;
        check_obs(rf_if.pc_out);

        // Byte write of F merged with a same-cycle flag write
        rf_if.wr_en = 1'b1;
        rf_if.wr_sel = RegF;
        rf_if.wr_data = 8'h5A;
        rf_if.flag_wr_mask = 4'b0001;
        rf_if.flag_wr_data = 4'b0000;
        expect_val("f_byte_flag_merge", 16'h0040);
        tick;
        idle;
        rf_if.rd_b_sel = RegF;
        #1;
        check_obs({8'h00, rf_if.rd_b_data});

        // EI delay
        rf_if.ime_op = ImeEi;
        rf_if.instr_done = 1'b1;
        expect_val("ei_same_done", 16'd0);
        tick;
        idle;
        check_obs({15'd0, rf_if.ime_out});
        expect_val("ei_pending_no_done", 16'd0);
        tick;
        check_obs({15'd0, rf_if.ime_out});
        rf_if.instr_done = 1'b1;
        expect_val("ei_next_done", 16'd1);
        tick;
        idle;
        check_obs({15'd0, rf_if.ime_out});
        rf_if.ime_op = ImeDi;
        expect_val("di_from_on", 16'd0);
        tick;
        idle;
        check_obs({15'd0, rf_if.ime_out});

        // DI cancels a pending EI
        rf_if.ime_op = ImeEi;
        tick;
        rf_if.ime_op = ImeDi;
        tick;
        idle;
        rf_if.instr_done = 1'b1;
        tick;
        tick;
        idle;
        expect_val("di_cancels_pending", 16'd0);
        check_obs({15'd0, rf_if.ime_out});

        // RETI and EI while ON
        rf_if.ime_op = ImeReti;
        expect_val("reti_on", 16'd1);
        tick;
        idle;
        check_obs({15'd0, rf_if.ime_out});
        rf_if.ime_op = ImeEi;
        rf_if.instr_done = 1'b1;
        expect_val("ei_while_on", 16'd1);
        tick;
        idle;
        check_obs({15'd0, rf_if.ime_out});

        // Asynchronous reset mid-cycle drops the in-flight write
        rf_if.wr_en = 1'b1;
        rf_if.wr_sel = RegA;
        rf_if.wr_data = 8'h77;
        rf_if.rd_a_sel = RegA;
        #2;
        reset_n = 1'b0;
        #1;
        expect_val("async_rst_a", {8'h00, INIT_A});
        expect_val("async_rst_ime", 16'd0);
        expect_val("async_rst_pc", INIT_PC);
        expect_val("rst_write_lost", {8'h00, INIT_A});
        check_obs({8'h00, rf_if.rd_a_data});
        check_obs({15'd0, rf_if.ime_out});
        check_obs(rf_if.pc_out);
        tick;
        check_obs({8'h00, rf_if.rd_a_data});
        idle;
        @(negedge clk);
        reset_n = 1'b1;

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
